// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the commit stage: exception codes, exception bit positions, trace entry layout.
// No logic; ecode_of_rank maps a priority rank (0 = vector MSB) to its exception code.
// No flow control.
package wb_commit_unit_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_IPE  = 6'h0E;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  // Bit positions in a 16-bit exception vector; fetch-side and memory-side TLBR/PPI both exist.
  localparam int EXCP_INT    = 15;
  localparam int EXCP_ADE    = 14;
  localparam int EXCP_TLBR_F = 13;
  localparam int EXCP_PIF    = 12;
  localparam int EXCP_PPI_F  = 11;
  localparam int EXCP_SYS    = 10;
  localparam int EXCP_BRK    = 9;
  localparam int EXCP_INE    = 8;
  localparam int EXCP_IPE    = 7;
  localparam int EXCP_ALE    = 6;
  localparam int EXCP_TLBR_M = 5;
  localparam int EXCP_PME    = 4;
  localparam int EXCP_PPI_M  = 3;
  localparam int EXCP_PIS    = 2;
  localparam int EXCP_PIL    = 1;
  localparam int EXCP_RANKS  = 15;

  localparam int TRACE_W = 69;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_t;

  function automatic logic [5:0] ecode_of_rank(input int unsigned rank);
    case (rank)
      0:       return ECODE_INT;
      1:       return ECODE_ADE;
      2:       return ECODE_TLBR;
      3:       return ECODE_PIF;
      4:       return ECODE_PPI;
      5:       return ECODE_SYS;
      6:       return ECODE_BRK;
      7:       return ECODE_INE;
      8:       return ECODE_IPE;
      9:       return ECODE_ALE;
      10:      return ECODE_TLBR;
      11:      return ECODE_PME;
      12:      return ECODE_PPI;
      13:      return ECODE_PIS;
      14:      return ECODE_PIL;
      default: return 6'h00;
    endcase
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Trace FIFO: up to NPUSH entries pushed per cycle (compacted in lane order), one popped per cycle when non-empty.
// Latency: an entry pushed in cycle N can be popped from cycle N+1.
// No internal backpressure: the writer must respect free; the pop is not credited to same-cycle pushes.
module wb_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 69,
  parameter int NPUSH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NPUSH-1:0]                  push_en,
  input  logic [NPUSH-1:0][WIDTH-1:0]       push_dat,
  output logic                              pop_vld,
  output logic [WIDTH-1:0]                  pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]        free
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [PW-1:0]    slot [NPUSH];
  int               n_push;

  // Each enabled lane lands in the next free slot after the older enabled lanes.
  always_comb begin
    n_push = 0;
    for (int i = 0; i < NPUSH; i++) begin
      slot[i] = PW'((int'(wr_ptr) + n_push) % DEPTH);
      if (push_en[i]) n_push = n_push + 1;
    end
  end

  assign pop_vld = (count != '0);
  assign pop_dat = mem[rd_ptr];
  assign free    = CW'(DEPTH) - count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= PW'((int'(wr_ptr) + n_push) % DEPTH);
      if (pop_vld) rd_ptr <= PW'((int'(rd_ptr) + 1) % DEPTH);
      count  <= CW'(int'(count) + n_push - (pop_vld ? 1 : 0));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPUSH; i++)
      if (push_en[i]) mem[slot[i]] <= push_dat[i];
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Multi-lane write-back/commit: resolves oldest exception/ertn, squashes younger lanes; WB_TRACE_EN adds the debug trace FIFO.
// Latency: one cycle from MS acceptance to commit; debug trace entries appear one cycle after their pop.
// Backpressure: with WB_TRACE_EN the group stalls (ws_allowin low) until the FIFO can hold all its writes.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int EXCP_W      = 16,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ms_to_ws_valid,
  output logic                    ws_allowin,
  input  logic [LANES-1:0]        ms_lane_valid,
  input  logic [32*LANES-1:0]     ms_pc,
  input  logic [LANES-1:0]        ms_gr_we,
  input  logic [5*LANES-1:0]      ms_dest,
  input  logic [32*LANES-1:0]     ms_result,
  input  logic [EXCP_W*LANES-1:0] ms_excp_num,
  input  logic [LANES-1:0]        ms_ertn,
  input  logic                    ms_csr_we,
  input  logic                    ms_res_from_csr,
  input  logic [13:0]             ms_csr_num,
  input  logic [31:0]             ms_csr_wmask,
  input  logic [31:0]             ms_csr_wdata,
  input  logic [31:0]             csr_rdata,
  output logic                    csr_we,
  output logic [13:0]             csr_num,
  output logic [31:0]             csr_wmask,
  output logic [31:0]             csr_wdata,
  output logic [LANES-1:0]        rf_we,
  output logic [5*LANES-1:0]      rf_waddr,
  output logic [32*LANES-1:0]     rf_wdata,
  output logic [LANES-1:0]        fwd_valid,
  output logic [5*LANES-1:0]      fwd_dest,
  output logic [32*LANES-1:0]     fwd_data,
  output logic                    excp_flush,
  output logic                    ertn_flush,
  output logic [5:0]              ecode,
  output logic [31:0]             epc,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_we,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  localparam int KW    = $clog2(LANES + 1);
  localparam int NRANK = (EXCP_W < EXCP_RANKS) ? EXCP_W : EXCP_RANKS;

  logic                          ws_valid, ws_ready_go, commit;
  logic [LANES-1:0]              lane_valid_r, gr_we_r, ertn_r;
  logic [LANES-1:0][31:0]        pc_r, result_r, wdata_c;
  logic [LANES-1:0][4:0]         dest_r;
  logic [LANES-1:0][EXCP_W-1:0]  excp_r;
  logic                          csr_we_r, res_from_csr_r;
  logic [KW-1:0]                 kill;
  logic                          ertn_k;
  logic [EXCP_W-1:0]             excp_k;
  logic [31:0]                   pc_k;
  logic [LANES-1:0]              fwd_c;

  assign ws_allowin = !ws_valid || ws_ready_go;
  assign commit     = ws_valid && ws_ready_go;

  always_ff @(posedge clk) begin
    if (reset) ws_valid <= 1'b0;
    else if (ws_allowin) ws_valid <= ms_to_ws_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_valid_r <= '0; gr_we_r <= '0; ertn_r <= '0; pc_r <= '0; result_r <= '0;
      dest_r <= '0; excp_r <= '0; csr_we_r <= 1'b0; res_from_csr_r <= 1'b0;
      csr_num <= '0; csr_wmask <= '0; csr_wdata <= '0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      lane_valid_r <= ms_lane_valid; gr_we_r <= ms_gr_we; ertn_r <= ms_ertn; pc_r <= ms_pc;
      result_r <= ms_result; dest_r <= ms_dest; excp_r <= ms_excp_num;
      csr_we_r <= ms_csr_we; res_from_csr_r <= ms_res_from_csr;
      csr_num <= ms_csr_num; csr_wmask <= ms_csr_wmask; csr_wdata <= ms_csr_wdata;
    end
  end

  // Kill point: oldest valid lane carrying an exception or ertn; LANES when the group is clean.
  always_comb begin
    kill = KW'(LANES);
    for (int i = LANES - 1; i >= 0; i--)
      if (lane_valid_r[i] && (excp_r[i] != '0 || ertn_r[i])) kill = KW'(i);
    excp_k = '0;
    ertn_k = 1'b0;
    pc_k   = '0;
    for (int i = 0; i < LANES; i++)
      if (kill == KW'(i)) begin
        excp_k = excp_r[i];
        ertn_k = ertn_r[i];
        pc_k   = pc_r[i];
      end
  end

  always_comb begin
    ecode = '0;
    for (int r = NRANK - 1; r >= 0; r--)
      if (excp_k[EXCP_W-1-r]) ecode = ecode_of_rank(r);
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      fwd_c[i]   = ws_valid && lane_valid_r[i] && gr_we_r[i] && (KW'(i) < kill);
      wdata_c[i] = result_r[i];
    end
    if (res_from_csr_r) wdata_c[0] = csr_rdata;
  end

  assign fwd_valid  = fwd_c;
  assign fwd_dest   = dest_r;
  assign fwd_data   = wdata_c;
  assign rf_we      = fwd_c & {LANES{ws_ready_go}};
  assign rf_waddr   = dest_r;
  assign rf_wdata   = wdata_c;
  assign excp_flush = commit && (excp_k != '0);
  assign ertn_flush = commit && ertn_k && (excp_k == '0);
  assign epc        = pc_k;
  assign csr_we     = commit && csr_we_r && (kill != '0);

`ifdef WB_TRACE_EN
  logic                                 pop_vld;
  trace_t                               pop_dat;
  trace_t [LANES-1:0]                   push_dat;
  logic [$clog2(TRACE_DEPTH+1)-1:0]     free;

  always_comb begin
    for (int i = 0; i < LANES; i++) push_dat[i] = '{pc: pc_r[i], wnum: dest_r[i], wdata: wdata_c[i]};
  end

  wb_trace_fifo #(.DEPTH(TRACE_DEPTH), .WIDTH(TRACE_W), .NPUSH(LANES)) u_trace_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_en  (rf_we),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .free     (free)
  );

  // Room is judged on the pre-pop occupancy so the group never relies on this cycle's pop.
  assign ws_ready_go = int'(free) >= $countones(fwd_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      debug_wb_rf_we    <= 4'h0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else if (pop_vld) begin
      debug_wb_rf_we    <= 4'hF;
      debug_wb_pc       <= pop_dat.pc;
      debug_wb_rf_wnum  <= pop_dat.wnum;
      debug_wb_rf_wdata <= pop_dat.wdata;
    end else begin
      debug_wb_rf_we    <= 4'h0;
    end
  end
`else
  assign ws_ready_go       = (TRACE_DEPTH > 0);
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_we    = 4'h0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboarded bench for wb_commit_unit: directed groups, stall/reset cases, then random groups vs a reference model.
module tb_wb_commit_unit;

  localparam int L  = 2;
  localparam int EW = 16;
  localparam int D  = 4;
`ifdef WB_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic              clk, reset;
  logic              ms_to_ws_valid, ws_allowin;
  logic [L-1:0]      ms_lane_valid, ms_gr_we, ms_ertn;
  logic [32*L-1:0]   ms_pc, ms_result;
  logic [5*L-1:0]    ms_dest;
  logic [EW*L-1:0]   ms_excp_num;
  logic              ms_csr_we, ms_res_from_csr;
  logic [13:0]       ms_csr_num, csr_num;
  logic [31:0]       ms_csr_wmask, ms_csr_wdata, csr_rdata, csr_wmask, csr_wdata;
  logic              csr_we, excp_flush, ertn_flush;
  logic [L-1:0]      rf_we, fwd_valid;
  logic [5*L-1:0]    rf_waddr, fwd_dest;
  logic [32*L-1:0]   rf_wdata, fwd_data;
  logic [5:0]        ecode;
  logic [31:0]       epc, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]        debug_wb_rf_we;
  logic [4:0]        debug_wb_rf_wnum;

  wb_commit_unit #(.LANES(L), .EXCP_W(EW), .TRACE_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_lane_valid(ms_lane_valid), .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_result(ms_result), .ms_excp_num(ms_excp_num), .ms_ertn(ms_ertn),
    .ms_csr_we(ms_csr_we), .ms_res_from_csr(ms_res_from_csr), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wdata(ms_csr_wdata), .csr_rdata(csr_rdata),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .ecode(ecode), .epc(epc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file stand-in: read data is a fixed scramble of the CSR number.
  function automatic logic [31:0] csr_model(input logic [13:0] n);
    return {n, 18'h2A5C3} ^ 32'h1234_5678;
  endfunction
  assign csr_rdata = csr_model(csr_num);

  typedef struct packed {
    logic [L-1:0]          lv, we, ertn;
    logic [L-1:0][31:0]    pc, res;
    logic [L-1:0][4:0]     dest;
    logic [L-1:0][EW-1:0]  excp;
    logic                  csr_we, rfc;
    logic [13:0]           csr_num;
    logic [31:0]           wmask, wdata;
  } grp_t;

  typedef struct packed {
    logic [L-1:0]          we, fwd;
    logic [L-1:0][4:0]     waddr;
    logic [L-1:0][31:0]    wdata;
    logic                  ef, erf;
    logic [5:0]            ecode;
    logic [31:0]           epc;
    logic                  cwe;
    logic [13:0]           cnum;
    logic [31:0]           cmask, cdata;
  } obs_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } tr_t;

  obs_t exp_q[$];
  tr_t  tr_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Exception code table, most significant vector bit first.
  function automatic logic [5:0] ref_ecode(input logic [EW-1:0] v);
    for (int b = 15; b >= 1; b--)
      if (v[b]) begin
        case (b)
          15: return 6'h00;  14: return 6'h08;  13: return 6'h3F;  12: return 6'h03;
          11: return 6'h07;  10: return 6'h0B;  9:  return 6'h0C;  8:  return 6'h0D;
          7:  return 6'h0E;  6:  return 6'h09;  5:  return 6'h3F;  4:  return 6'h04;
          3:  return 6'h07;  2:  return 6'h02;  default: return 6'h01;
        endcase
      end
    return 6'h00;
  endfunction

  task automatic expect_group(input grp_t g);
    obs_t e;
    int   k;
    e = '0;
    k = L;
    for (int i = L - 1; i >= 0; i--)
      if (g.lv[i] && (g.excp[i] != 0 || g.ertn[i])) k = i;
    for (int i = 0; i < k; i++)
      if (g.lv[i] && g.we[i]) begin
        e.we[i]    = 1'b1;
        e.waddr[i] = g.dest[i];
        e.wdata[i] = (i == 0 && g.rfc) ? csr_model(g.csr_num) : g.res[i];
        if (TRACE) tr_q.push_back('{pc: g.pc[i], wnum: g.dest[i], wdata: e.wdata[i]});
      end
    e.fwd = e.we;
    if (k < L) begin
      e.ef    = (g.excp[k] != 0);
      e.erf   = !e.ef && g.ertn[k];
      e.ecode = ref_ecode(g.excp[k]);
      e.epc   = g.pc[k];
    end
    if (g.csr_we && k > 0) begin
      e.cwe = 1'b1; e.cnum = g.csr_num; e.cmask = g.wmask; e.cdata = g.wdata;
    end
    if (e.we != 0 || e.ef || e.erf || e.cwe) exp_q.push_back(e);
  endtask

  task automatic drive(input grp_t g);
    ms_lane_valid = g.lv; ms_gr_we = g.we; ms_ertn = g.ertn; ms_pc = g.pc; ms_result = g.res;
    ms_dest = g.dest; ms_excp_num = g.excp; ms_csr_we = g.csr_we; ms_res_from_csr = g.rfc;
    ms_csr_num = g.csr_num; ms_csr_wmask = g.wmask; ms_csr_wdata = g.wdata;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the group.
  task automatic send_group(input grp_t g);
    bit ok;
    ok = 1'b0;
    drive(g);
    ms_to_ws_valid = 1'b1;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = ws_allowin;
      @(posedge clk);
    end
    #1;
    ms_to_ws_valid = 1'b0;
    if (ok) expect_group(g);
    else chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  function automatic grp_t rand_grp();
    grp_t g;
    g = '0;
    g.lv = L'($urandom); g.we = L'($urandom); g.csr_we = 1'($urandom); g.rfc = 1'($urandom);
    g.csr_num = 14'($urandom); g.wmask = $urandom; g.wdata = $urandom;
    for (int i = 0; i < L; i++) begin
      g.pc[i]   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      g.res[i]  = $urandom;
      g.dest[i] = 5'($urandom);
      case ($urandom_range(0, 7))
        0:       g.excp[i] = EW'(1) << $urandom_range(0, EW - 1);
        1:       g.excp[i] = EW'($urandom);
        default: g.excp[i] = '0;
      endcase
      g.ertn[i] = ($urandom_range(0, 9) == 0);
    end
    return g;
  endfunction

  function automatic grp_t two_writes(input logic [4:0] d0, input logic [4:0] d1, input logic [31:0] base);
    grp_t g;
    g = '0;
    g.lv = 2'b11; g.we = 2'b11;
    g.dest[0] = d0; g.dest[1] = d1;
    g.res[0] = base; g.res[1] = base + 32'h11;
    g.pc[0] = base & 32'hFFFF_FFFC; g.pc[1] = (base & 32'hFFFF_FFFC) + 32'd4;
    return g;
  endfunction

  // Monitor: compares every observable commit and every debug trace entry against the queues.
  initial begin
    obs_t o, e;
    tr_t  t;
    forever begin
      @(negedge clk);
      if (!reset) begin
        o = '0;
        o.we = rf_we; o.fwd = fwd_valid; o.ef = excp_flush; o.erf = ertn_flush; o.cwe = csr_we;
        for (int i = 0; i < L; i++)
          if (rf_we[i]) begin
            o.waddr[i] = rf_waddr[i*5 +: 5];
            o.wdata[i] = rf_wdata[i*32 +: 32];
          end
        if (excp_flush || ertn_flush) begin o.ecode = ecode; o.epc = epc; end
        if (csr_we) begin o.cnum = csr_num; o.cmask = csr_wmask; o.cdata = csr_wdata; end
        if (rf_we != 0 || excp_flush || ertn_flush || csr_we) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL commit_unexpected: got %h expected no commit", o);
          end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
              n_fail++;
              $display("FAIL commit: got %h expected %h", o, e);
            end
          end
        end
        if (debug_wb_rf_we == 4'hF) begin
          t = '{pc: debug_wb_pc, wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};
          n_tests++;
          if (tr_q.size() == 0) begin
            n_fail++;
            $display("FAIL trace_unexpected: got %h expected no entry", t);
          end else if (t !== tr_q[0]) begin
            n_fail++;
            $display("FAIL trace: got %h expected %h", t, tr_q[0]);
            void'(tr_q.pop_front());
          end else begin
            void'(tr_q.pop_front());
          end
        end else if (debug_wb_rf_we != 4'h0) begin
          chk("debug_we_value", 64'(debug_wb_rf_we), 64'h0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_rf_we"}, 64'(rf_we), 64'h0);
    chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'h0);
    chk({tag, "_flushes"}, 64'({excp_flush, ertn_flush, csr_we}), 64'h0);
    chk({tag, "_debug_we"}, 64'(debug_wb_rf_we), 64'h0);
    chk({tag, "_debug_fields"}, 64'({debug_wb_pc, debug_wb_rf_wnum} | 37'(debug_wb_rf_wdata)), 64'h0);
    chk({tag, "_allowin"}, 64'(ws_allowin), 64'h1);
  endtask

  initial begin
    grp_t g;
    reset = 1'b1;
    ms_to_ws_valid = 1'b0;
    drive('0);
    @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Two clean writes r4/r5 in the same cycle; trace shows r4 then r5.
    g = two_writes(5'd4, 5'd5, 32'h11);
    g.res[1] = 32'h22;
    send_group(g);
    // Lane 0 SYS squashes lane 1 write of r6.
    g = two_writes(5'd7, 5'd6, 32'h1C00_0100);
    g.we[0] = 1'b0; g.excp[0] = 16'h0400; g.csr_we = 1'b1;
    send_group(g);
    // Lane 0 writes r7, lane 1 ALE+ADE: ADE wins, epc is lane 1 pc.
    g = two_writes(5'd7, 5'd8, 32'h1C00_0200);
    g.excp[1] = 16'h4040;
    send_group(g);
    // Lane 0 ertn with a CSR write pending: ertn flush only.
    g = two_writes(5'd9, 5'd10, 32'h1C00_0300);
    g.ertn[0] = 1'b1; g.csr_we = 1'b1; g.csr_num = 14'h6; g.wdata = 32'hABCD;
    send_group(g);
    // CSR read on lane 0 with CSR write committing.
    g = two_writes(5'd11, 5'd12, 32'h1C00_0400);
    g.rfc = 1'b1; g.csr_we = 1'b1; g.csr_num = 14'h0C1; g.wmask = 32'hFF; g.wdata = 32'h5A;
    send_group(g);
    repeat (10) begin @(posedge clk); #1; end

    // Three back-to-back two-write groups: the third waits for trace room.
    send_group(two_writes(5'd1, 5'd2, 32'h100));
    send_group(two_writes(5'd3, 5'd4, 32'h200));
    send_group(two_writes(5'd5, 5'd6, 32'h300));
    @(negedge clk);
    chk("allowin_third_group", 64'(ws_allowin), TRACE ? 64'h0 : 64'h1);
    chk("fwd_visible_in_stall", 64'(fwd_valid), 64'h3);
    repeat (10) begin @(posedge clk); #1; end

    // Reset while the third group is stalled discards the group and the FIFO.
    send_group(two_writes(5'd13, 5'd14, 32'h400));
    send_group(two_writes(5'd15, 5'd16, 32'h500));
    send_group(two_writes(5'd17, 5'd18, 32'h600));
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    tr_q.delete();
    reset = 1'b0;
    @(negedge clk);
    check_quiet("mid_stall_reset");
    repeat (10) begin @(posedge clk); #1; end

    for (int n = 0; n < 300; n++) begin
      send_group(rand_grp());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    repeat (20) begin @(posedge clk); #1; end
    chk("commit_queue_drained", 64'(exp_q.size()), 64'h0);
    chk("trace_queue_drained", 64'(tr_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
